ascon_perm_arbiter: RTL and testbench
=====================================

// Module: ascon_perm_arbiter
// PURPOSE
//  Shares one Ascon permutation core between two requesters: the encryption engine (ENC)
//  and the decryption engine (DEC) of the AEAD top level.
//  Arbitrates round-robin, registers the selected 320-bit state and round count, and
//  pulses the core start. Returns the permuted state with a done/err pulse to the owner.
//  Watchdog flags a core that never raises ready.
// PARAMETERS
//  W        320  permutation state width (bits)
//  RW       4    round-count field width
//  MAXR     12   largest legal round count (a); legal range 1..MAXR
//  TIMEOUT  64   WAIT cycles before the watchdog aborts (>=2)
// PORTS
//  clk             in   1    rising-edge clock
//  rst             in   1    asynchronous, active-high reset
//  enc_req         in   1    ENC requests a permutation; held high until enc_gnt
//  enc_rounds      in   RW   ENC round count
//  enc_state       in   W    ENC input state
//  enc_gnt         out  1    1-cycle pulse: ENC inputs captured
//  enc_done        out  1    1-cycle pulse: res_state valid for ENC
//  enc_err         out  1    1-cycle pulse with enc_done: illegal rounds or timeout
//  dec_req         in   1    DEC request (same rules as ENC)
//  dec_rounds      in   RW   DEC round count
//  dec_state       in   W    DEC input state
//  dec_gnt         out  1    DEC capture pulse
//  dec_done        out  1    DEC done pulse
//  dec_err         out  1    DEC error pulse
//  res_state       out  W    result state; valid while done is high, held until next result
//  perm_start      out  1    1-cycle start pulse to the permutation core
//  perm_rounds     out  RW   registered round count to the core
//  perm_state_in   out  W    registered state to the core
//  perm_state_out  in   W    core result
//  perm_ready      in   1    core result valid (sampled in WAIT only)
//  busy            out  1    high in every state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, timer=0, last_owner=DEC (ENC wins the first tie).
//   Reset mid-operation aborts immediately; no done is issued; core result is discarded.
//  FSM states: IDLE, ISSUE, WAIT, RESP.
//  IDLE: on an edge with any req high, select the owner.
//   - Single requester wins.
//   - Both requesting: the requester != last_owner wins.
//   - Capture the owner's state/rounds into perm_state_in/perm_rounds.
//   - rounds==0 or rounds>MAXR: go to RESP with err=1 and res_state=captured state
//     (core is not started). Otherwise go to ISSUE.
//  ISSUE (exactly 1 cycle): perm_start=1 and owner gnt=1 (gnt is also pulsed on the
//   illegal-rounds path, in the RESP cycle). timer<=0. Go to WAIT.
//  WAIT: each cycle timer<=timer+1.
//   - perm_ready=1: res_state<=perm_state_out; go to RESP with err=0.
//   - Else if timer==TIMEOUT-1: res_state<=perm_state_in; go to RESP with err=1.
//   - perm_ready and timeout on the same edge: ready wins.
//  RESP (exactly 1 cycle): owner done=1, err as latched; last_owner<=owner; go to IDLE.
//  Latency: req sampled at edge N gives gnt/perm_start in cycle N+1. Ready sampled at
//   edge M gives done in cycle M+1. Minimum request spacing is IDLE+ISSUE+WAIT+RESP.
//  perm_ready in IDLE, ISSUE or RESP is ignored.
//  req dropped before the IDLE sample is not served. Changes to req/state after gnt
//   have no effect on the current operation.
//  A requester holding req across its own done is re-arbitrated in the IDLE cycle that
//   follows; with both requesting, the owners alternate.
//  perm_state_in/perm_rounds hold their value until the next capture.
//  Never more than one gnt/done/err pulse set per cycle; outputs of the non-owner stay 0.
// TESTING
//  T1 ENC only, rounds=12, core ready 12 cycles after start
//     -> enc_gnt+perm_start 1 cycle after req; enc_done with res_state=core output; dec_* stay 0.
//  T2 enc_req and dec_req rise on the same edge after reset, both held
//     -> order ENC, DEC, ENC, DEC; busy deasserts for 1 IDLE cycle between each.
//  T3 dec_rounds=0, then dec_rounds=13 -> dec_done+dec_err, res_state=dec_state,
//     perm_start never pulses.
//  T4 core never asserts perm_ready, TIMEOUT=64 -> enc_err+enc_done exactly 65 cycles
//     after perm_start; res_state=input state.
//  T5 perm_ready pulsed in IDLE and in the ISSUE cycle -> ignored; the done pulse
//     follows only the WAIT-phase ready.
//  T6 rst asserted in WAIT -> all outputs 0 asynchronously; after release, a tie grants ENC first.

Source files
------------

// File: rtl/ascon_perm_arbiter.sv
// ascon_perm_arbiter: round-robin share of one Ascon permutation core
// between the ENC and DEC engines, with a WAIT-phase watchdog.
module ascon_perm_arbiter #(
  parameter int W       = 320,
  parameter int RW      = 4,
  parameter int MAXR    = 12,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enc_req,
  input  logic [RW-1:0] enc_rounds,
  input  logic [W-1:0]  enc_state,
  output logic          enc_gnt,
  output logic          enc_done,
  output logic          enc_err,
  input  logic          dec_req,
  input  logic [RW-1:0] dec_rounds,
  input  logic [W-1:0]  dec_state,
  output logic          dec_gnt,
  output logic          dec_done,
  output logic          dec_err,
  output logic [W-1:0]  res_state,
  output logic          perm_start,
  output logic [RW-1:0] perm_rounds,
  output logic [W-1:0]  perm_state_in,
  input  logic [W-1:0]  perm_state_out,
  input  logic          perm_ready,
  output logic          busy
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RMAX  = RW'(MAXR);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  typedef enum logic {
    OWN_ENC = 1'b0,
    OWN_DEC = 1'b1
  } own_t;

  state_t        state;
  own_t          owner;
  own_t          last_owner;
  logic [TW-1:0] timer;

  logic          any_req;
  logic          pick_dec;
  logic [RW-1:0] sel_rounds;
  logic [W-1:0]  sel_state;
  logic          sel_bad;
  logic          own_dec;
  logic          tmo;

  // Arbitration: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    any_req    = enc_req | dec_req;
    pick_dec   = dec_req & (~enc_req | (last_owner == OWN_ENC));
    sel_rounds = pick_dec ? dec_rounds : enc_rounds;
    sel_state  = pick_dec ? dec_state : enc_state;
    sel_bad    = (sel_rounds == '0) || (sel_rounds > RMAX);
    own_dec    = (owner == OWN_DEC);
    tmo        = (timer == TLAST);
  end

  // Control FSM with all handshake outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      owner         <= OWN_ENC;
      last_owner    <= OWN_DEC;
      timer         <= '0;
      enc_gnt       <= 1'b0;
      enc_done      <= 1'b0;
      enc_err       <= 1'b0;
      dec_gnt       <= 1'b0;
      dec_done      <= 1'b0;
      dec_err       <= 1'b0;
      perm_start    <= 1'b0;
      perm_rounds   <= '0;
      perm_state_in <= '0;
      res_state     <= '0;
      busy          <= 1'b0;
    end else begin
      enc_gnt    <= 1'b0;
      enc_done   <= 1'b0;
      enc_err    <= 1'b0;
      dec_gnt    <= 1'b0;
      dec_done   <= 1'b0;
      dec_err    <= 1'b0;
      perm_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            owner         <= own_t'(pick_dec);
            perm_rounds   <= sel_rounds;
            perm_state_in <= sel_state;
            busy          <= 1'b1;
            enc_gnt       <= ~pick_dec;
            dec_gnt       <= pick_dec;
            if (sel_bad) begin
              // Illegal round count: answer at once, core untouched.
              res_state <= sel_state;
              enc_done  <= ~pick_dec;
              enc_err   <= ~pick_dec;
              dec_done  <= pick_dec;
              dec_err   <= pick_dec;
              state     <= RESP;
            end else begin
              perm_start <= 1'b1;
              state      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          timer <= timer + 1'b1;
          if (perm_ready) begin
            res_state <= perm_state_out;
            enc_done  <= ~own_dec;
            dec_done  <= own_dec;
            state     <= RESP;
          end else if (tmo) begin
            // Watchdog: hand back the unpermuted state flagged as error.
            res_state <= perm_state_in;
            enc_done  <= ~own_dec;
            enc_err   <= ~own_dec;
            dec_done  <= own_dec;
            dec_err   <= own_dec;
            state     <= RESP;
          end
        end
        RESP: begin
          last_owner <= owner;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_perm_arbiter.sv
// tb_ascon_perm_arbiter: random and directed stimulus against a
// transaction-schedule model of the arbiter.
module tb_ascon_perm_arbiter;

  localparam int W       = 320;
  localparam int RW      = 4;
  localparam int MAXR    = 12;
  localparam int TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          enc_req;
  logic [RW-1:0] enc_rounds;
  logic [W-1:0]  enc_state;
  logic          enc_gnt;
  logic          enc_done;
  logic          enc_err;
  logic          dec_req;
  logic [RW-1:0] dec_rounds;
  logic [W-1:0]  dec_state;
  logic          dec_gnt;
  logic          dec_done;
  logic          dec_err;
  logic [W-1:0]  res_state;
  logic          perm_start;
  logic [RW-1:0] perm_rounds;
  logic [W-1:0]  perm_state_in;
  logic [W-1:0]  perm_state_out;
  logic          perm_ready;
  logic          busy;

  always #5 clk = ~clk;

  ascon_perm_arbiter #(
    .W(W), .RW(RW), .MAXR(MAXR), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enc_req(enc_req),
    .enc_rounds(enc_rounds),
    .enc_state(enc_state),
    .enc_gnt(enc_gnt),
    .enc_done(enc_done),
    .enc_err(enc_err),
    .dec_req(dec_req),
    .dec_rounds(dec_rounds),
    .dec_state(dec_state),
    .dec_gnt(dec_gnt),
    .dec_done(dec_done),
    .dec_err(dec_err),
    .res_state(res_state),
    .perm_start(perm_start),
    .perm_rounds(perm_rounds),
    .perm_state_in(perm_state_in),
    .perm_state_out(perm_state_out),
    .perm_ready(perm_ready),
    .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  // Model: one operation record, timed in cycle numbers.
  int            k = 0;
  bit            have_op;
  int            c;
  int            d;
  bit            own;
  bit            legal;
  bit            errf;
  bit            last;
  int            lat;
  logic [W-1:0]  st;
  logic [RW-1:0] rds;
  logic [W-1:0]  res;

  // Stimulus controls.
  int p_enc = 0;
  int p_dec = 0;
  int fr_enc = -1;
  int fr_dec = -1;
  int lat_fix = -1;
  int spur = 0;

  // Observed events.
  int   t_gnt, t_start, t_done, t_req;
  int   n_start = 0;
  int   n_decerr = 0;
  int   n_dec = 0;
  logic last_err;
  logic glog[$];

  task automatic chk(string n, logic [W-1:0] a, logic [W-1:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", n, k, a, e);
    end
  endtask

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [RW-1:0] pick_r();
    int x;
    if ($urandom_range(0, 9) == 0) begin
      x = $urandom_range(0, 3);
      return (x == 0) ? RW'(0) : RW'(MAXR + x);
    end
    return RW'($urandom_range(1, MAXR));
  endfunction

  task automatic model_reset();
    have_op = 1'b0;
    c = -10;
    d = -1;
    own = 1'b0;
    legal = 1'b0;
    errf = 1'b0;
    last = 1'b1;
    st = '0;
    rds = '0;
    res = '0;
  endtask

  task automatic compare();
    bit g, s, dn, er, bz;
    logic [7:0] ex, ac;
    g  = have_op && (k == c + 1);
    s  = g && legal;
    dn = have_op && (d == k);
    er = dn && errf;
    bz = have_op && (k >= c + 1) && (d < 0 || k <= d);
    ex = {g && !own, dn && !own, er && !own,
          g && own, dn && own, er && own, s, bz};
    ac = {enc_gnt, enc_done, enc_err,
          dec_gnt, dec_done, dec_err, perm_start, busy};
    chk("ctrl", W'(ac), W'(ex));
    chk("perm_rounds", W'(perm_rounds), W'(rds));
    chk("perm_state_in", perm_state_in, st);
    if (dn) chk("res_state", res_state, res);
    if (enc_gnt | dec_gnt) begin
      t_gnt = k;
      glog.push_back(dec_gnt);
    end
    if (perm_start) begin
      t_start = k;
      n_start++;
    end
    if (enc_done | dec_done) begin
      t_done = k;
      last_err = enc_err | dec_err;
    end
    if (dec_err) n_decerr++;
    if (dec_gnt | dec_done | dec_err) n_dec++;
  endtask

  task automatic drive();
    bit eh, dh, wt;
    eh = enc_req && !(have_op && c == k - 1 && !own);
    dh = dec_req && !(have_op && c == k - 1 && own);
    if (!eh) begin
      enc_req = ($urandom_range(0, 99) < p_enc);
      enc_rounds = (fr_enc >= 0) ? RW'(fr_enc) : pick_r();
      enc_state = rnd_w();
    end
    if (!dh) begin
      dec_req = ($urandom_range(0, 99) < p_dec);
      dec_rounds = (fr_dec >= 0) ? RW'(fr_dec) : pick_r();
      dec_state = rnd_w();
    end
    wt = have_op && legal && d < 0 && k >= c + 2;
    if (wt) perm_ready = (k == c + 2 + lat);
    else perm_ready = (spur == 1) || (spur == 2 && $urandom_range(0, 3) == 0);
    perm_state_out = rnd_w();
  endtask

  task automatic update();
    int r;
    if (have_op && legal && d < 0 && k >= c + 2) begin
      if (perm_ready) begin
        d = k + 1;
        res = perm_state_out;
        errf = 1'b0;
      end else if (k == c + 1 + TIMEOUT) begin
        d = k + 1;
        res = st;
        errf = 1'b1;
      end
    end
    if ((!have_op || (d >= 0 && k > d)) && (enc_req || dec_req)) begin
      own = dec_req && (!enc_req || !last);
      last = own;
      c = k;
      have_op = 1'b1;
      st = own ? dec_state : enc_state;
      rds = own ? dec_rounds : enc_rounds;
      legal = (rds != 0) && (rds <= MAXR);
      if (!legal) begin
        d = k + 1;
        res = st;
        errf = 1'b1;
      end else begin
        d = -1;
        if (lat_fix >= 0) lat = lat_fix;
        else begin
          r = $urandom_range(0, 9);
          if (r < 8) lat = $urandom_range(0, 15);
          else if (r == 8) lat = $urandom_range(62, 64);
          else lat = 1000;
        end
      end
    end
  endtask

  task automatic step();
    compare();
    drive();
    update();
    @(negedge clk);
    k++;
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  initial begin
    logic [W-1:0] saved;
    logic [3:0] ord;
    int s0;
    rst = 1'b1;
    enc_req = 1'b0;
    dec_req = 1'b0;
    enc_rounds = '0;
    dec_rounds = '0;
    enc_state = '0;
    dec_state = '0;
    perm_state_out = '0;
    perm_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_ctrl", W'({enc_gnt, enc_done, enc_err, dec_gnt, dec_done,
                          dec_err, perm_start, busy}), '0);
    chk("reset_res", res_state | perm_state_in | W'(perm_rounds), '0);
    rst = 1'b0;
    run(3);

    // T1: ENC alone, core ready 12 cycles after start.
    n_dec = 0;
    lat_fix = 11; fr_enc = 12; p_enc = 100;
    t_req = k;
    step();
    p_enc = 0;
    run(30);
    chk("t1_gnt_lat", W'(t_gnt - t_req), W'(1));
    chk("t1_done_lat", W'(t_done - t_start), W'(13));
    chk("t1_dec_quiet", W'(n_dec), '0);

    // T3: illegal round counts on DEC.
    s0 = n_start; n_decerr = 0;
    fr_dec = 0; p_dec = 100;
    step();
    p_dec = 0;
    run(5);
    fr_dec = 13; p_dec = 100;
    step();
    saved = dec_state;
    p_dec = 0;
    run(5);
    chk("t3_no_start", W'(n_start - s0), '0);
    chk("t3_err_cnt", W'(n_decerr), W'(2));
    chk("t3_res", res_state, saved);
    fr_dec = -1;

    // T4: core never ready, watchdog fires.
    lat_fix = 1000; fr_enc = 5; p_enc = 100;
    step();
    p_enc = 0;
    run(80);
    chk("t4_lat", W'(t_done - t_start), W'(TIMEOUT + 1));
    chk("t4_err", W'(last_err), W'(1));

    // T5: ready outside WAIT must be ignored.
    spur = 1; lat_fix = 5; p_enc = 100;
    step();
    p_enc = 0;
    run(20);
    chk("t5_lat", W'(t_done - t_start), W'(7));
    spur = 0;

    // T6: reset in WAIT, then a tie.
    lat_fix = 1000; p_enc = 100;
    step();
    p_enc = 0;
    run(10);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_async", W'({enc_gnt, enc_done, enc_err, dec_gnt, dec_done,
                         dec_err, perm_start, busy}) | W'(perm_rounds), '0);
    chk("rst_async_data", res_state | perm_state_in, '0);
    enc_req = 1'b0;
    dec_req = 1'b0;
    perm_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // T2: both requesting from the same edge.
    glog.delete();
    lat_fix = 3; fr_enc = 4; fr_dec = 4;
    p_enc = 100; p_dec = 100;
    run(40);
    p_enc = 0; p_dec = 0;
    run(20);
    for (int i = 0; i < 4; i++) ord[3-i] = (glog.size() > i) ? glog[i] : 1'bx;
    chk("t2_order", W'(ord), W'(4'b0101));

    // Random traffic.
    lat_fix = -1; fr_enc = -1; fr_dec = -1;
    spur = 2; p_enc = 30; p_dec = 30;
    run(3000);
    p_enc = 0; p_dec = 0; spur = 0;
    run(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
